// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV immediate generator for the decode stage.
// Extracts and sign-extends I/S/B/U/J immediates to XLEN bits, carries a
// sideband tag and flags unsupported ImmSrc codes. A main slot drives the
// outputs and a skid slot absorbs one extra beat, so in_ready can be a pure
// register while still sustaining one instruction per cycle.
// Optional feature: define IMM_GEN_ZICSR_EN to decode ImmSrc 011 as the
// zero-extended CSR uimm (Z-type); otherwise 011 is reported as illegal.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   generate
      if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
         $error("imm_gen_pipe: XLEN must be 32 or 64");
      end
   endgenerate

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t             state_q;
   occ_t             state_d;

   logic             accept;
   logic             drain;
   logic             load_m;
   logic             load_k;
   logic             move_k;

   logic [XLEN-1:0]  dec_imm;
   logic             dec_ill;

   logic [XLEN-1:0]  m_imm;
   logic [TAG_W-1:0] m_tag;
   logic             m_ill;
   logic [XLEN-1:0]  k_imm;
   logic [TAG_W-1:0] k_tag;
   logic             k_ill;

   // Opcode field plays no part in any immediate format.
   logic             unused_opcode;
   assign unused_opcode = ^in_inst[6:0];

   // Both handshake outputs come straight from the occupancy register.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid & in_ready;
   assign drain     = out_valid & out_ready;

   assign out_imm     = m_imm;
   assign out_tag     = m_tag;
   assign out_illegal = m_ill;

   // Combinational decode of the incoming instruction into an XLEN immediate.
   always_comb begin
      dec_imm = '0;
      dec_ill = 1'b0;
      case (in_imm_src)
         3'b000:  dec_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
         3'b001:  dec_imm = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         3'b101:  dec_imm = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
         3'b010:  dec_imm = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};
         3'b110:  dec_imm = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
         3'b011:  dec_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
`endif
         default: dec_ill = 1'b1;
      endcase
   end

   // Occupancy state register; reset empties both slots immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next occupancy from accept/drain; flush overrides everything.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
               if (accept && !drain) begin
                  state_d = FULL;
               end else if (!accept && drain) begin
                  state_d = EMPTY;
               end
            end
            FULL:    if (drain) state_d = ONE;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Slot load enables: which slot captures the decode, or skid-to-main move.
   always_comb begin
      load_m = 1'b0;
      load_k = 1'b0;
      move_k = 1'b0;
      if (!flush) begin
         case (state_q)
            EMPTY: load_m = accept;
            ONE: begin
               load_m = accept & drain;
               load_k = accept & ~drain;
            end
            FULL:    move_k = drain;
            default: ;
         endcase
      end
   end

   // Main slot data: fresh decode, or the older skid entry when draining from FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_imm <= '0;
         m_tag <= '0;
         m_ill <= 1'b0;
      end else if (load_m) begin
         m_imm <= dec_imm;
         m_tag <= in_tag;
         m_ill <= dec_ill;
      end else if (move_k) begin
         m_imm <= k_imm;
         m_tag <= k_tag;
         m_ill <= k_ill;
      end
   end

   // Skid slot data: captures the decode when main is held under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_imm <= '0;
         k_tag <= '0;
         k_ill <= 1'b0;
      end else if (load_k) begin
         k_imm <= dec_imm;
         k_tag <= in_tag;
         k_ill <= dec_ill;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives a 32-bit and a 64-bit imm_gen_pipe from the same
// inputs and compares both against a queue-based reference model every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_imm_gen_pipe;

   localparam int TAG_W = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              out_ready;
   logic [31:0]       in_inst;
   logic [2:0]        in_imm_src;
   logic [TAG_W-1:0]  in_tag;

   logic              in_ready32, out_valid32, out_illegal32;
   logic [31:0]       out_imm32;
   logic [TAG_W-1:0]  out_tag32;
   logic              in_ready64, out_valid64, out_illegal64;
   logic [63:0]       out_imm64;
   logic [TAG_W-1:0]  out_tag64;

   typedef struct packed {
      logic [63:0]      imm;
      logic [TAG_W-1:0] tag;
      logic             ill;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   passes = 0;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
      .in_imm_src(in_imm_src), .in_tag(in_tag),
      .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
      .out_tag(out_tag32), .out_illegal(out_illegal32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
      .in_imm_src(in_imm_src), .in_tag(in_tag),
      .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
      .out_tag(out_tag64), .out_illegal(out_illegal64)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   // Reference decode: build each format's raw field as a signed number and
   // let assignment into a 64-bit value do the sign extension.
   function automatic exp_t modelDecode(input logic [31:0] inst, input logic [2:0] src,
                                        input logic [TAG_W-1:0] tag);
      exp_t e;
      logic signed [11:0] s12;
      logic signed [12:0] s13;
      logic signed [20:0] s21;
      logic signed [31:0] s32;
      longint v;
      v = 0;
      e.tag = tag;
      e.ill = 1'b0;
      case (src)
         3'd0: begin s12 = inst[31:20]; v = s12; end
         3'd1: begin s12 = {inst[31:25], inst[11:7]}; v = s12; end
         3'd5: begin s13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; v = s13; end
         3'd2: begin s32 = {inst[31:12], 12'h000}; v = s32; end
         3'd6: begin s21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; v = s21; end
`ifdef IMM_GEN_ZICSR_EN
         3'd3: v = longint'(inst[19:15]);
`endif
         default: e.ill = 1'b1;
      endcase
      e.imm = v;
      return e;
   endfunction

   // One comparison: counts it, and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one cycle's worth of inputs; called just after a falling edge.
   task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [2:0] src,
                                input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
      in_valid   = v;
      in_inst    = inst;
      in_imm_src = src;
      in_tag     = tag;
      out_ready  = ordy;
      flush      = fl;
   endtask

   // Reference model: a FIFO of at most two decoded entries. On each rising
   // edge it applies flush, or else pops on a drain and pushes on an accept.
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         automatic bit acc = in_valid && (expq.size() < 2);
         automatic bit drn = out_ready && (expq.size() > 0);
         if (flush) begin
            expq.delete();
         end else begin
            if (drn) void'(expq.pop_front());
            if (acc) expq.push_back(modelDecode(in_inst, in_imm_src, in_tag));
         end
      end
   end

   // Asynchronous reset empties the model at once, like the hardware.
   always @(negedge rst_n) expq.delete();

   // Per-cycle comparison of both DUTs against the model, half a cycle after
   // the rising edge; under reset everything must read as idle zero.
   always @(negedge clk) begin
      if (rst_n === 1'b0) begin
         checkOutput("rst_out_valid", 64'(out_valid32), 64'd0);
         checkOutput("rst_in_ready", 64'(in_ready32), 64'd1);
         checkOutput("rst_out_imm", 64'(out_imm32), 64'd0);
      end else if (rst_n === 1'b1) begin
         checkOutput("in_ready32", 64'(in_ready32), 64'(expq.size() < 2));
         checkOutput("in_ready64", 64'(in_ready64), 64'(expq.size() < 2));
         checkOutput("out_valid32", 64'(out_valid32), 64'(expq.size() != 0));
         checkOutput("out_valid64", 64'(out_valid64), 64'(expq.size() != 0));
         if (expq.size() != 0) begin
            checkOutput("out_imm32", 64'(out_imm32), 64'(expq[0].imm[31:0]));
            checkOutput("out_imm64", out_imm64, expq[0].imm);
            checkOutput("out_tag32", 64'(out_tag32), 64'(expq[0].tag));
            checkOutput("out_tag64", 64'(out_tag64), 64'(expq[0].tag));
            checkOutput("out_ill32", 64'(out_illegal32), 64'(expq[0].ill));
            checkOutput("out_ill64", 64'(out_illegal64), 64'(expq[0].ill));
         end
      end
   end

   // Directed scenarios followed by a randomized soak.
   initial begin
      exp_t e;
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);

      // Pin the reference model with hand-computed values.
      e = modelDecode(32'hFFF00093, 3'd0, 5'd0);
      checkOutput("pin_addi", e.imm, 64'hFFFF_FFFF_FFFF_FFFF);
      e = modelDecode(32'h80000063, 3'd5, 5'd0);
      checkOutput("pin_beq", e.imm, 64'hFFFF_FFFF_FFFF_F000);
      e = modelDecode(32'h0010006F, 3'd6, 5'd0);
      checkOutput("pin_jal", e.imm, 64'h800);
      e = modelDecode(32'h000FD073, 3'd3, 5'd0);
`ifdef IMM_GEN_ZICSR_EN
      checkOutput("pin_csr", {e.imm[62:0], e.ill}, {63'h1F, 1'b0});
`else
      checkOutput("pin_csr", {e.imm[62:0], e.ill}, {63'h0, 1'b1});
`endif

      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // addi x1,x0,-1: all-ones immediate, tag echoed one cycle later.
      @(negedge clk) applyStimulus(1'b1, 32'hFFF00093, 3'd0, 5'd5, 1'b1, 1'b0);
      @(negedge clk) applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
      checkOutput("t1_imm", 64'(out_imm32), 64'hFFFF_FFFF);
      checkOutput("t1_tag", 64'(out_tag32), 64'd5);
      checkOutput("t1_ill", 64'(out_illegal32), 64'd0);

      // beq with -4096 on both widths.
      @(negedge clk) applyStimulus(1'b1, 32'h80000063, 3'd5, 5'd9, 1'b1, 1'b0);
      @(negedge clk) applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
      checkOutput("t2_imm32", 64'(out_imm32), 64'hFFFF_F000);
      checkOutput("t2_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_F000);

      // Three back-to-back instructions against a stalled consumer.
      @(negedge clk) applyStimulus(1'b1, 32'h00100093, 3'd0, 5'd1, 1'b0, 1'b0);
      @(negedge clk) applyStimulus(1'b1, 32'h00200093, 3'd0, 5'd2, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_ready_full", 64'(in_ready32), 64'd0);
      applyStimulus(1'b1, 32'h00300093, 3'd0, 5'd3, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("t3_hold_tag", 64'(out_tag32), 64'd1);
      applyStimulus(1'b1, 32'h00300093, 3'd0, 5'd3, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t3_second_tag", 64'(out_tag32), 64'd2);
      checkOutput("t3_ready_back", 64'(in_ready32), 64'd1);
      @(negedge clk);
      checkOutput("t3_third_tag", 64'(out_tag32), 64'd3);
      checkOutput("t3_third_imm", 64'(out_imm32), 64'd3);
      applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("t3_drained", 64'(out_valid32), 64'd0);

      // Flush while FULL with a new instruction offered.
      @(negedge clk) applyStimulus(1'b1, 32'h00A00093, 3'd0, 5'd10, 1'b0, 1'b0);
      @(negedge clk) applyStimulus(1'b1, 32'h00B00093, 3'd0, 5'd11, 1'b0, 1'b0);
      @(negedge clk) applyStimulus(1'b1, 32'h00C00093, 3'd0, 5'd12, 1'b0, 1'b1);
      @(negedge clk) applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
      checkOutput("t4_flush_valid", 64'(out_valid32), 64'd0);
      checkOutput("t4_flush_ready", 64'(in_ready32), 64'd1);
      // Flush in ONE with a same-cycle accept: the accept is dropped.
      @(negedge clk) applyStimulus(1'b1, 32'h00D00093, 3'd0, 5'd13, 1'b0, 1'b0);
      @(negedge clk) applyStimulus(1'b1, 32'h00E00093, 3'd0, 5'd14, 1'b1, 1'b1);
      @(negedge clk) applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
      checkOutput("t4_flush_accept", 64'(out_valid32), 64'd0);

      // csrrwi uimm=0x1F with ImmSrc 011.
      @(negedge clk) applyStimulus(1'b1, 32'h000FD073, 3'd3, 5'd7, 1'b1, 1'b0);
      @(negedge clk) applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
      checkOutput("t5_imm", 64'(out_imm32), 64'h1F);
      checkOutput("t5_ill", 64'(out_illegal32), 64'd0);
`else
      checkOutput("t5_imm", 64'(out_imm32), 64'h0);
      checkOutput("t5_ill", 64'(out_illegal32), 64'd1);
`endif

      // Asynchronous reset while FULL, then jal +2048.
      @(negedge clk) applyStimulus(1'b1, 32'h00100093, 3'd0, 5'd20, 1'b0, 1'b0);
      @(negedge clk) applyStimulus(1'b1, 32'h00200093, 3'd0, 5'd21, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
      #1;
      checkOutput("t6_rst_valid", 64'(out_valid32), 64'd0);
      checkOutput("t6_rst_ready", 64'(in_ready32), 64'd1);
      checkOutput("t6_rst_tag", 64'(out_tag32), 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk) applyStimulus(1'b1, 32'h0010006F, 3'd6, 5'd4, 1'b1, 1'b0);
      @(negedge clk) applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
      checkOutput("t6_jal_imm", 64'(out_imm32), 64'h800);
      checkOutput("t6_jal_tag", 64'(out_tag32), 64'd4);

      // Randomized traffic with back-pressure, all ImmSrc codes and rare flushes.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         applyStimulus(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                       TAG_W'($urandom), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 40) == 0));
      end
      @(negedge clk) applyStimulus(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("final_empty", 64'(out_valid32), 64'd0);

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
